// File: rtl/ep_fifo_bus_port.sv
// ep_fifo_bus_port
// Bus-side access port for four USB endpoint FIFOs. A bus access is a
// single-byte strobe/ack cycle. Writes go into the selected endpoint's TX FIFO
// and reads come from the selected endpoint's RX FIFO. An access that hits a
// full TX FIFO or an empty RX FIFO completes at once with busErr set, and it is
// counted in a saturating error counter.
//
// Ports:
//   clk, rst_n                     bus clock, async active-low reset
//   busStb/busWe/busEp/busDataIn   access request (held until busAck)
//   busDataOut/busAck/busErr       access completion and read byte
//   errCount/errCountClr           saturating errored-access count and its sync clear
//   TxFifoWData, TxFifoEPnWEn      shared TX write byte and per-EP write enables
//   TxFifoEPnFull                  per-EP TX full flags (sampled in IDLE only)
//   RxFifoEPnREn                   per-EP RX read enables
//   RxFifoEPnData                  per-EP RX read data (valid the cycle after REn)
//   RxFifoEPnEmpty                 per-EP RX empty flags (sampled in IDLE only)
module ep_fifo_bus_port (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       busStb,
  input  logic       busWe,
  input  logic [1:0] busEp,
  input  logic [7:0] busDataIn,
  output logic [7:0] busDataOut,
  output logic       busAck,
  output logic       busErr,
  output logic [7:0] errCount,
  input  logic       errCountClr,
  output logic [7:0] TxFifoWData,
  output logic       TxFifoEP0WEn,
  output logic       TxFifoEP1WEn,
  output logic       TxFifoEP2WEn,
  output logic       TxFifoEP3WEn,
  input  logic       TxFifoEP0Full,
  input  logic       TxFifoEP1Full,
  input  logic       TxFifoEP2Full,
  input  logic       TxFifoEP3Full,
  output logic       RxFifoEP0REn,
  output logic       RxFifoEP1REn,
  output logic       RxFifoEP2REn,
  output logic       RxFifoEP3REn,
  input  logic [7:0] RxFifoEP0Data,
  input  logic [7:0] RxFifoEP1Data,
  input  logic [7:0] RxFifoEP2Data,
  input  logic [7:0] RxFifoEP3Data,
  input  logic       RxFifoEP0Empty,
  input  logic       RxFifoEP1Empty,
  input  logic       RxFifoEP2Empty,
  input  logic       RxFifoEP3Empty
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_READ_WAIT,
    S_ACK
  } state_t;

  state_t state_q, state_d;

  logic [1:0] ep_q;
  logic [7:0] wdata_q;
  logic [7:0] rdata_q;
  logic       err_q;
  logic [7:0] cnt_q;

  logic [3:0] full_vec;
  logic [3:0] empty_vec;
  logic [7:0] rx_data [4];
  logic [3:0] wen_vec;
  logic [3:0] ren_vec;

  logic       accept;
  logic       acc_err;

  assign full_vec  = {TxFifoEP3Full, TxFifoEP2Full, TxFifoEP1Full, TxFifoEP0Full};
  assign empty_vec = {RxFifoEP3Empty, RxFifoEP2Empty, RxFifoEP1Empty, RxFifoEP0Empty};
  assign rx_data[0] = RxFifoEP0Data;
  assign rx_data[1] = RxFifoEP1Data;
  assign rx_data[2] = RxFifoEP2Data;
  assign rx_data[3] = RxFifoEP3Data;

  // Flags are only consulted at acceptance; later flag changes cannot abort.
  assign accept  = (state_q == S_IDLE) && busStb;
  assign acc_err = accept && (busWe ? full_vec[busEp] : empty_vec[busEp]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (busStb) begin
          if (acc_err)    state_d = S_ACK;
          else if (busWe) state_d = S_WRITE;
          else            state_d = S_READ;
        end
      end
      S_WRITE:     state_d = S_ACK;
      S_READ:      state_d = S_READ_WAIT;
      S_READ_WAIT: state_d = S_ACK;
      S_ACK:       state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output decode: enables and ack come from state and latched fields only,
  // so the asynchronous reset clears them immediately.
  always_comb begin
    wen_vec = '0;
    ren_vec = '0;
    if (state_q == S_WRITE) wen_vec[ep_q] = 1'b1;
    if (state_q == S_READ)  ren_vec[ep_q] = 1'b1;
    busAck = (state_q == S_ACK);
    busErr = (state_q == S_ACK) && err_q;
  end

  assign TxFifoEP0WEn = wen_vec[0];
  assign TxFifoEP1WEn = wen_vec[1];
  assign TxFifoEP2WEn = wen_vec[2];
  assign TxFifoEP3WEn = wen_vec[3];
  assign RxFifoEP0REn = ren_vec[0];
  assign RxFifoEP1REn = ren_vec[1];
  assign RxFifoEP2REn = ren_vec[2];
  assign RxFifoEP3REn = ren_vec[3];

  assign TxFifoWData = wdata_q;
  assign busDataOut  = rdata_q;
  assign errCount    = cnt_q;

  // Access datapath: latched request fields, read byte and error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ep_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (accept) begin
        ep_q    <= busEp;
        wdata_q <= busDataIn;
        err_q   <= acc_err;
        if (acc_err && !busWe) rdata_q <= '0;
      end
      if (state_q == S_READ_WAIT) rdata_q <= rx_data[ep_q];
      if (errCountClr) begin
        cnt_q <= '0;
      end else if (acc_err && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ep_fifo_bus_port.sv
module tb_ep_fifo_bus_port;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busStb, busWe, errCountClr;
  logic [1:0] busEp;
  logic [7:0] busDataIn;
  logic [7:0] busDataOut, errCount, TxFifoWData;
  logic       busAck, busErr;
  logic       wen0, wen1, wen2, wen3, ren0, ren1, ren2, ren3;
  logic       full0, full1, full2, full3;
  logic       empty0, empty1, empty2, empty3;
  logic [7:0] rd0, rd1, rd2, rd3;
  logic [3:0] wen, ren;

  int errors = 0;
  int checks = 0;

  assign wen = {wen3, wen2, wen1, wen0};
  assign ren = {ren3, ren2, ren1, ren0};

  always #5 clk = ~clk;

  ep_fifo_bus_port dut (
    .clk(clk), .rst_n(rst_n),
    .busStb(busStb), .busWe(busWe), .busEp(busEp), .busDataIn(busDataIn),
    .busDataOut(busDataOut), .busAck(busAck), .busErr(busErr),
    .errCount(errCount), .errCountClr(errCountClr),
    .TxFifoWData(TxFifoWData),
    .TxFifoEP0WEn(wen0), .TxFifoEP1WEn(wen1), .TxFifoEP2WEn(wen2), .TxFifoEP3WEn(wen3),
    .TxFifoEP0Full(full0), .TxFifoEP1Full(full1), .TxFifoEP2Full(full2), .TxFifoEP3Full(full3),
    .RxFifoEP0REn(ren0), .RxFifoEP1REn(ren1), .RxFifoEP2REn(ren2), .RxFifoEP3REn(ren3),
    .RxFifoEP0Data(rd0), .RxFifoEP1Data(rd1), .RxFifoEP2Data(rd2), .RxFifoEP3Data(rd3),
    .RxFifoEP0Empty(empty0), .RxFifoEP1Empty(empty1), .RxFifoEP2Empty(empty2), .RxFifoEP3Empty(empty3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; busStb = 1'b0; busWe = 1'b0; busEp = 2'd0; busDataIn = 8'h00;
    errCountClr = 1'b0;
    {full3, full2, full1, full0} = 4'b0000;
    {empty3, empty2, empty1, empty0} = 4'b0000;
    rd0 = 8'h10; rd1 = 8'h11; rd2 = 8'h12; rd3 = 8'h13;
    step(); step();

    chk("rst_ack", {31'd0, busAck}, 32'd0);
    chk("rst_err", {31'd0, busErr}, 32'd0);
    chk("rst_dout", {24'd0, busDataOut}, 32'h00);
    chk("rst_cnt", {24'd0, errCount}, 32'h00);
    chk("rst_wdata", {24'd0, TxFifoWData}, 32'h00);
    chk("rst_en", {24'd0, wen, ren}, 32'h00);
    rst_n = 1'b1;
    step();

    // Write 0xA5 to EP2
    busStb = 1'b1; busWe = 1'b1; busEp = 2'd2; busDataIn = 8'hA5;
    step();                                   // cycle 1
    busDataIn = 8'hFF; busEp = 2'd0;          // must be ignored after acceptance
    chk("wr_wen_c1", {28'd0, wen}, 32'b0100);
    chk("wr_wdata", {24'd0, TxFifoWData}, 32'hA5);
    chk("wr_ack_c1", {31'd0, busAck}, 32'd0);
    step();                                   // cycle 2
    chk("wr_ack_c2", {30'd0, busAck, busErr}, 32'b10);
    chk("wr_wen_c2", {28'd0, wen}, 32'd0);
    busStb = 1'b0;
    step();

    // Read EP1, data 0x3C appears the cycle after REn
    busStb = 1'b1; busWe = 1'b0; busEp = 2'd1;
    step();                                   // cycle 1
    chk("rd_ren_c1", {28'd0, ren}, 32'b0010);
    chk("rd_ack_c1", {31'd0, busAck}, 32'd0);
    rd1 = 8'h3C;
    step();                                   // cycle 2
    chk("rd_ren_c2", {28'd0, ren}, 32'd0);
    chk("rd_ack_c2", {31'd0, busAck}, 32'd0);
    step();                                   // cycle 3
    rd1 = 8'h77;
    chk("rd_ack_c3", {30'd0, busAck, busErr}, 32'b10);
    chk("rd_dout", {24'd0, busDataOut}, 32'h3C);
    busStb = 1'b0;
    step();
    chk("rd_dout_hold", {24'd0, busDataOut}, 32'h3C);

    // Write to full EP3
    full3 = 1'b1;
    busStb = 1'b1; busWe = 1'b1; busEp = 2'd3; busDataIn = 8'h42;
    step();                                   // cycle 1
    chk("wfull_ack", {30'd0, busAck, busErr}, 32'b11);
    chk("wfull_en", {28'd0, wen}, 32'd0);
    chk("wfull_cnt", {24'd0, errCount}, 32'd1);
    busStb = 1'b0;
    step();
    chk("wfull_en_after", {24'd0, wen, ren}, 32'd0);

    // Read from empty EP0
    empty0 = 1'b1;
    busStb = 1'b1; busWe = 1'b0; busEp = 2'd0;
    step();
    chk("rempty_ack", {30'd0, busAck, busErr}, 32'b11);
    chk("rempty_en", {28'd0, ren}, 32'd0);
    chk("rempty_dout", {24'd0, busDataOut}, 32'h00);
    chk("rempty_cnt", {24'd0, errCount}, 32'd2);
    busStb = 1'b0;
    step();

    // Errored accesses back to back: 252 more -> 0xFE, then 8 more saturate
    busStb = 1'b1;
    for (int i = 0; i < 252; i++) begin
      step();                                 // ack cycle
      step();                                 // next access cycle 0
    end
    chk("cnt_fe", {24'd0, errCount}, 32'hFE);
    for (int i = 0; i < 8; i++) begin
      step();
      step();
    end
    chk("cnt_sat", {24'd0, errCount}, 32'hFF);

    // Clear coincident with another errored access
    errCountClr = 1'b1;
    step();
    errCountClr = 1'b0;
    chk("clr_cnt", {24'd0, errCount}, 32'h00);
    chk("clr_err", {30'd0, busAck, busErr}, 32'b11);
    busStb = 1'b0;
    empty0 = 1'b0; full3 = 1'b0;
    step();

    // Reset while a write enable is active
    busStb = 1'b1; busWe = 1'b1; busEp = 2'd1; busDataIn = 8'h33;
    step();
    chk("rstw_pre", {28'd0, wen}, 32'b0010);
    rst_n = 1'b0;
    #1;
    chk("rstw_wen", {28'd0, wen}, 32'd0);
    busStb = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Reset in READ_WAIT
    busStb = 1'b1; busWe = 1'b0; busEp = 2'd2; rd2 = 8'h99;
    step();                                   // READ
    step();                                   // READ_WAIT
    busStb = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstr_en", {24'd0, wen, ren}, 32'd0);
    chk("rstr_ack", {31'd0, busAck}, 32'd0);
    step();
    chk("rstr_dout", {24'd0, busDataOut}, 32'h00);
    rst_n = 1'b1;
    step();

    // Standard write to EP0 after reset
    busStb = 1'b1; busWe = 1'b1; busEp = 2'd0; busDataIn = 8'h5A;
    step();
    chk("post_wen", {28'd0, wen}, 32'b0001);
    chk("post_wdata", {24'd0, TxFifoWData}, 32'h5A);
    step();
    chk("post_ack", {30'd0, busAck, busErr}, 32'b10);
    chk("post_wen_off", {28'd0, wen}, 32'd0);
    busStb = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
